// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared types and constants for the falling-piece movement logic.
//   POS_W    : width of every position/rotation field
//   ROT_MASK : keeps rotation in 0..3 (bits [1:0])
//   state_t  : movement controller FSM states
//   move_t   : kind of candidate move under check
//   rot_next : clockwise rotation step with wrap 3 -> 0
// -----------------------------------------------------------------------------
package tetris_pkg;

    localparam int POS_W = 10;
    localparam logic [POS_W-1:0] ROT_MASK = 10'h003;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_COMMIT    = 3'd2,
        ST_LOCK      = 3'd3,
        ST_SPAWN_CHK = 3'd4,
        ST_RESPAWN   = 3'd5,
        ST_OVER      = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        MV_DOWN  = 2'd0,
        MV_ROT   = 2'd1,
        MV_LEFT  = 2'd2,
        MV_RIGHT = 2'd3
    } move_t;

    function automatic logic [POS_W-1:0] rot_next(input logic [POS_W-1:0] rot);
        return (rot + 10'd1) & ROT_MASK;
    endfunction

endpackage

// File: rtl/chk_handshake.sv
// -----------------------------------------------------------------------------
// chk_handshake
// Owns the collision-check request level and its timeout counter.
// A start pulse raises the request on the next cycle; the request stays high
// until the checker acks or CHK_TIMEOUT cycles pass without an ack, in which
// case the candidate is reported as a hit.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   i_start  : begin a new check (request rises next cycle)
//   i_ack    : checker result valid pulse
//   i_hit    : checker collision result, valid with i_ack
//   o_req    : request level to the checker (registered)
//   o_done   : check finished this cycle (ack or timeout)
//   o_hit    : result for this check, valid with o_done
// -----------------------------------------------------------------------------
module chk_handshake #(
    parameter int CHK_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_ack,
    input  logic i_hit,
    output logic o_req,
    output logic o_done,
    output logic o_hit
);

    // Last busy cycle index: the request is held for exactly CHK_TIMEOUT cycles.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(CHK_TIMEOUT - 1);

    logic            r_busy;
    logic [TO_W-1:0] r_cnt;

    // Completion decode: an ack wins over a timeout in the same cycle.
    always_comb begin
        o_done = 1'b0;
        o_hit  = 1'b0;
        if (r_busy) begin
            if (i_ack) begin
                o_done = 1'b1;
                o_hit  = i_hit;
            end else if (r_cnt == TO_LAST) begin
                o_done = 1'b1;
                o_hit  = 1'b1;
            end else begin
                o_done = 1'b0;
            end
        end else begin
            o_done = 1'b0;
        end
    end

    // Request level and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
        end else if (o_done) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (r_busy) begin
            r_cnt  <= r_cnt + TO_W'(1);
        end else begin
            r_cnt  <= r_cnt;
        end
    end

    assign o_req = r_busy;

endmodule

// File: rtl/block_move_ctrl.sv
// -----------------------------------------------------------------------------
// block_move_ctrl
// Movement controller for the falling piece. Turns button pulses and the
// gravity tick into candidate moves, has each checked by the board collision
// checker, and commits only legal ones. A blocked down move locks the piece,
// then the spawn position is checked to respawn or declare game over.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   btn_left/right/rot          : move request pulses (honoured only in IDLE)
//   fall_tick                   : gravity pulse (remembered if busy)
//   cur_x/cur_y/cur_rot         : current piece position from position register
//   chk_req, chk_x/y/rot        : collision-check request and candidate
//   chk_ack, chk_hit            : checker result pulse and collision flag
//   new_x/y/rot, refresh        : committed position and its 1-cycle strobe
//   lock                        : 1-cycle strobe to write the piece into board
//   pos_reset                   : 1-cycle respawn strobe to position register
//   game_over                   : sticky flag, cleared only by rst
// -----------------------------------------------------------------------------
module block_move_ctrl
    import tetris_pkg::*;
#(
    parameter logic [9:0] SPAWN_X     = 10'd9,
    parameter int         CHK_TIMEOUT = 15,
    parameter int         TO_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_rot,
    input  logic             fall_tick,
    input  logic [POS_W-1:0] cur_x,
    input  logic [POS_W-1:0] cur_y,
    input  logic [POS_W-1:0] cur_rot,
    output logic             chk_req,
    output logic [POS_W-1:0] chk_x,
    output logic [POS_W-1:0] chk_y,
    output logic [POS_W-1:0] chk_rot,
    input  logic             chk_ack,
    input  logic             chk_hit,
    output logic [POS_W-1:0] new_x,
    output logic [POS_W-1:0] new_y,
    output logic [POS_W-1:0] new_rot,
    output logic             refresh,
    output logic             lock,
    output logic             pos_reset,
    output logic             game_over
);

    state_t           r_state;
    move_t            r_mv;
    logic             r_fall_pend;
    logic [POS_W-1:0] r_chk_x, r_chk_y, r_chk_rot;
    logic [POS_W-1:0] r_new_x, r_new_y, r_new_rot;
    logic             r_refresh, r_lock, r_pos_reset, r_game_over;

    logic             w_evt;
    move_t            w_mv;
    logic [POS_W-1:0] w_cx, w_cy, w_crot;
    logic             w_start, w_done, w_hit;

    // Candidate selection in priority order: gravity, rotate, left, right.
    always_comb begin
        w_evt  = 1'b0;
        w_mv   = MV_DOWN;
        w_cx   = cur_x;
        w_cy   = cur_y;
        w_crot = cur_rot;
        if (r_fall_pend || fall_tick) begin
            w_evt = 1'b1;
            w_mv  = MV_DOWN;
            w_cy  = cur_y + 10'd1;
        end else if (btn_rot) begin
            w_evt  = 1'b1;
            w_mv   = MV_ROT;
            w_crot = rot_next(cur_rot);
        end else if (btn_left) begin
            // The left wall is known locally, so column 0 never goes to the checker.
            w_evt = (cur_x != 10'd0);
            w_mv  = MV_LEFT;
            w_cx  = cur_x - 10'd1;
        end else if (btn_right) begin
            w_evt = 1'b1;
            w_mv  = MV_RIGHT;
            w_cx  = cur_x + 10'd1;
        end else begin
            w_evt = 1'b0;
        end
    end

    // A new handshake starts on an accepted move or on the way into the spawn check.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_start = w_evt;
        end else if (r_state == ST_LOCK) begin
            w_start = 1'b1;
        end else begin
            w_start = 1'b0;
        end
    end

    chk_handshake #(
        .CHK_TIMEOUT (CHK_TIMEOUT),
        .TO_W        (TO_W)
    ) u_hs (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_ack   (chk_ack),
        .i_hit   (chk_hit),
        .o_req   (chk_req),
        .o_done  (w_done),
        .o_hit   (w_hit)
    );

    // Gravity memory: ticks seen while busy are replayed once IDLE is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fall_pend <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_evt && (w_mv == MV_DOWN)) begin
                r_fall_pend <= 1'b0;
            end else begin
                r_fall_pend <= r_fall_pend;
            end
        end else if ((r_state != ST_OVER) && fall_tick) begin
            r_fall_pend <= 1'b1;
        end else begin
            r_fall_pend <= r_fall_pend;
        end
    end

    // Main FSM with registered candidate, commit data and strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mv        <= MV_DOWN;
            r_chk_x     <= '0;
            r_chk_y     <= '0;
            r_chk_rot   <= '0;
            r_new_x     <= '0;
            r_new_y     <= '0;
            r_new_rot   <= '0;
            r_refresh   <= 1'b0;
            r_lock      <= 1'b0;
            r_pos_reset <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            // Strobes default low so each lasts exactly one cycle.
            r_refresh   <= 1'b0;
            r_lock      <= 1'b0;
            r_pos_reset <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_evt) begin
                        r_chk_x   <= w_cx;
                        r_chk_y   <= w_cy;
                        r_chk_rot <= w_crot;
                        r_mv      <= w_mv;
                        r_state   <= ST_CHECK;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (w_done && !w_hit) begin
                        r_new_x   <= r_chk_x;
                        r_new_y   <= r_chk_y;
                        r_new_rot <= r_chk_rot;
                        r_refresh <= 1'b1;
                        r_state   <= ST_COMMIT;
                    end else if (w_done && (r_mv == MV_DOWN)) begin
                        r_lock    <= 1'b1;
                        r_state   <= ST_LOCK;
                    end else if (w_done) begin
                        r_state   <= ST_IDLE;
                    end else begin
                        r_state   <= ST_CHECK;
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_IDLE;
                end
                ST_LOCK: begin
                    r_chk_x   <= SPAWN_X;
                    r_chk_y   <= '0;
                    r_chk_rot <= '0;
                    r_state   <= ST_SPAWN_CHK;
                end
                ST_SPAWN_CHK: begin
                    if (w_done && !w_hit) begin
                        r_pos_reset <= 1'b1;
                        r_state     <= ST_RESPAWN;
                    end else if (w_done) begin
                        r_pos_reset <= 1'b1;
                        r_game_over <= 1'b1;
                        r_state     <= ST_OVER;
                    end else begin
                        r_state     <= ST_SPAWN_CHK;
                    end
                end
                ST_RESPAWN: begin
                    r_state <= ST_IDLE;
                end
                ST_OVER: begin
                    r_state <= ST_OVER;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign chk_x     = r_chk_x;
    assign chk_y     = r_chk_y;
    assign chk_rot   = r_chk_rot;
    assign new_x     = r_new_x;
    assign new_y     = r_new_y;
    assign new_rot   = r_new_rot;
    assign refresh   = r_refresh;
    assign lock      = r_lock;
    assign pos_reset = r_pos_reset;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_block_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_block_move_ctrl
// Scoreboard bench: expected checker requests and strobes are queued as each
// stimulus is driven and popped in order when the DUT produces them. The bench
// also models the position register (refresh loads new_*, pos_reset respawns).
// -----------------------------------------------------------------------------
module tb_block_move_ctrl;

    localparam int K_REQ  = 0;
    localparam int K_REF  = 1;
    localparam int K_LOCK = 2;
    localparam int K_PRST = 3;

    typedef struct {
        int kind;
        int x;
        int y;
        int r;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       btn_left, btn_right, btn_rot, fall_tick;
    logic [9:0] cur_x, cur_y, cur_rot;
    logic       chk_req;
    logic [9:0] chk_x, chk_y, chk_rot;
    logic       chk_ack, chk_hit;
    logic [9:0] new_x, new_y, new_rot;
    logic       refresh, lock, pos_reset, game_over;

    exp_t sb_q[$];
    int   n_tests;
    int   n_fail;
    logic prev_req;

    block_move_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_rot   (btn_rot),
        .fall_tick (fall_tick),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .cur_rot   (cur_rot),
        .chk_req   (chk_req),
        .chk_x     (chk_x),
        .chk_y     (chk_y),
        .chk_rot   (chk_rot),
        .chk_ack   (chk_ack),
        .chk_hit   (chk_hit),
        .new_x     (new_x),
        .new_y     (new_y),
        .new_rot   (new_rot),
        .refresh   (refresh),
        .lock      (lock),
        .pos_reset (pos_reset),
        .game_over (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int kind, input int x, input int y, input int r);
        exp_t e;
        e.kind = kind;
        e.x    = x;
        e.y    = y;
        e.r    = r;
        sb_q.push_back(e);
    endtask

    task automatic sb_event(input int kind, input int x, input int y, input int r);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val($sformatf("sb_unexpected_kind%0d", kind), 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val("sb_kind", kind, e.kind);
            check_val($sformatf("sb_x_kind%0d", kind), x, e.x);
            check_val($sformatf("sb_y_kind%0d", kind), y, e.y);
            check_val($sformatf("sb_rot_kind%0d", kind), r, e.r);
        end
    endtask

    // One clock: inputs held through the posedge, outputs observed at negedge.
    task automatic step();
        int n_strobe;
        @(posedge clk);
        @(negedge clk);
        n_strobe = int'(refresh) + int'(lock) + int'(pos_reset);
        check_val("strobe_excl", (n_strobe <= 1) ? 32'd1 : 32'd0, 32'd1);
        if (chk_req && !prev_req) sb_event(K_REQ, chk_x, chk_y, chk_rot);
        if (refresh) begin
            sb_event(K_REF, new_x, new_y, new_rot);
            cur_x   = new_x;
            cur_y   = new_y;
            cur_rot = new_rot;
        end
        if (lock) sb_event(K_LOCK, 0, 0, 0);
        if (pos_reset) begin
            sb_event(K_PRST, game_over, 0, 0);
            cur_x   = 10'd9;
            cur_y   = 10'd0;
            cur_rot = 10'd0;
        end
        prev_req = chk_req;
    endtask

    task automatic ack(input logic hit);
        chk_ack = 1'b1;
        chk_hit = hit;
        step();
        chk_ack = 1'b0;
        chk_hit = 1'b0;
    endtask

    task automatic set_cur(input int x, input int y, input int r);
        cur_x   = 10'(x);
        cur_y   = 10'(y);
        cur_rot = 10'(r);
    endtask

    initial begin
        int n_req;
        n_tests = 0;
        n_fail = 0;
        prev_req = 1'b0;
        rst = 1'b1;
        btn_left = 1'b0;
        btn_right = 1'b0;
        btn_rot = 1'b0;
        fall_tick = 1'b0;
        chk_ack = 1'b0;
        chk_hit = 1'b0;
        set_cur(5, 3, 0);

        // Reset state
        repeat (3) step();
        rst = 1'b0;
        check_val("rst_req", chk_req, 1'b0);
        check_val("rst_refresh", refresh, 1'b0);
        check_val("rst_lock", lock, 1'b0);
        check_val("rst_pos_reset", pos_reset, 1'b0);
        check_val("rst_game_over", game_over, 1'b0);
        check_val("rst_chk_x", chk_x, 10'd0);
        check_val("rst_new_x", new_x, 10'd0);
        step();

        // 1: gravity move, ack one cycle later, refresh in the third cycle
        set_cur(5, 3, 0);
        push(K_REQ, 5, 4, 0);
        push(K_REF, 5, 4, 0);
        fall_tick = 1'b1;
        step();
        fall_tick = 1'b0;
        check_val("t1_req", chk_req, 1'b1);
        ack(1'b0);
        check_val("t1_refresh_lat", refresh, 1'b1);
        check_val("t1_req_drop", chk_req, 1'b0);
        step();
        check_val("t1_refresh_once", refresh, 1'b0);

        // 2: rotation wraps 3 -> 0; left at column 0 is dropped
        set_cur(5, 3, 3);
        push(K_REQ, 5, 3, 0);
        push(K_REF, 5, 3, 0);
        btn_rot = 1'b1;
        step();
        btn_rot = 1'b0;
        ack(1'b0);
        check_val("t2_new_rot", new_rot, 10'd0);
        step();
        set_cur(0, 3, 0);
        btn_left = 1'b1;
        step();
        btn_left = 1'b0;
        check_val("t2_left0_req", chk_req, 1'b0);
        step();
        check_val("t2_left0_req2", chk_req, 1'b0);
        check_val("t2_left0_refresh", refresh, 1'b0);

        // 3: simultaneous events -> down first; tick during CHECK replays later
        set_cur(4, 2, 1);
        push(K_REQ, 4, 3, 1);
        fall_tick = 1'b1;
        btn_left = 1'b1;
        btn_rot = 1'b1;
        step();
        fall_tick = 1'b0;
        btn_left = 1'b0;
        btn_rot = 1'b0;
        fall_tick = 1'b1;
        btn_left = 1'b1;
        step();
        fall_tick = 1'b0;
        btn_left = 1'b0;
        push(K_REF, 4, 3, 1);
        push(K_REQ, 4, 4, 1);
        push(K_REF, 4, 4, 1);
        ack(1'b0);
        step();
        step();
        check_val("t3_pend_req", chk_req, 1'b1);
        check_val("t3_pend_y", chk_y, 10'd4);
        ack(1'b0);
        repeat (3) step();
        check_val("t3_sb_empty", sb_q.size(), 0);

        // 4: blocked down -> lock -> spawn check clear -> respawn
        set_cur(3, 18, 0);
        push(K_REQ, 3, 19, 0);
        push(K_LOCK, 0, 0, 0);
        push(K_REQ, 9, 0, 0);
        push(K_PRST, 0, 0, 0);
        fall_tick = 1'b1;
        step();
        fall_tick = 1'b0;
        ack(1'b1);
        check_val("t4_lock", lock, 1'b1);
        step();
        check_val("t4_spawn_req", chk_req, 1'b1);
        ack(1'b0);
        check_val("t4_pos_reset", pos_reset, 1'b1);
        step();
        check_val("t4_game_over", game_over, 1'b0);
        push(K_REQ, 10, 0, 0);
        btn_right = 1'b1;
        step();
        btn_right = 1'b0;
        ack(1'b1);
        step();
        check_val("t4_sb_empty", sb_q.size(), 0);

        // 5: spawn blocked -> game over, sticky, inputs ignored, rst clears
        set_cur(2, 17, 2);
        push(K_REQ, 2, 18, 2);
        push(K_LOCK, 0, 0, 0);
        push(K_REQ, 9, 0, 0);
        push(K_PRST, 1, 0, 0);
        fall_tick = 1'b1;
        step();
        fall_tick = 1'b0;
        ack(1'b1);
        step();
        ack(1'b1);
        check_val("t5_game_over", game_over, 1'b1);
        for (int i = 0; i < 6; i++) begin
            fall_tick = 1'b1;
            btn_left = 1'b1;
            btn_rot = 1'b1;
            step();
            check_val("t5_over_req", chk_req, 1'b0);
            check_val("t5_over_sticky", game_over, 1'b1);
        end
        fall_tick = 1'b0;
        btn_left = 1'b0;
        btn_rot = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("t5_rst_go", game_over, 1'b0);
        step();

        // 6: no ack on a left move -> timeout as hit, no refresh
        set_cur(6, 5, 0);
        push(K_REQ, 5, 5, 0);
        btn_left = 1'b1;
        step();
        btn_left = 1'b0;
        n_req = 0;
        for (int i = 0; i < 30 && chk_req; i++) begin
            n_req++;
            step();
        end
        check_val("t6_timeout_cycles", n_req, 15);
        step();
        check_val("t6_to_refresh", refresh, 1'b0);
        check_val("t6_to_req", chk_req, 1'b0);

        // 6b: rst mid-CHECK abandons the check and pending gravity
        push(K_REQ, 7, 5, 0);
        btn_right = 1'b1;
        step();
        btn_right = 1'b0;
        fall_tick = 1'b1;
        step();
        fall_tick = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("t6_rst_req", chk_req, 1'b0);
        check_val("t6_rst_chk_x", chk_x, 10'd0);
        check_val("t6_rst_new_x", new_x, 10'd0);
        check_val("t6_rst_go", game_over, 1'b0);
        repeat (5) step();
        check_val("t6_rst_idle_req", chk_req, 1'b0);
        check_val("final_sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/block_move_ctrl.md
Name: block_move_ctrl

Overview:
Movement controller for the falling tetromino. It drives the position register's inputs (new x/y/rotate plus refresh) and its err/reset input. It turns button events and the gravity tick into candidate moves, checks each one with the board collision checker over a req/ack handshake, and commits only legal moves. A blocked downward move locks the piece, then the controller respawns it or flags game over.

Parameters:
SPAWN_X, 9, spawn column; pos_reset returns the position register to (x=SPAWN_X, y=0, rot=0)
CHK_TIMEOUT, 15, maximum cycles to wait for chk_ack before treating the check as a hit
TO_W, 4, width of the timeout counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
btn_left  in  1  move-left request pulse
btn_right  in  1  move-right request pulse
btn_rot  in  1  rotate-clockwise request pulse
fall_tick  in  1  gravity pulse
cur_x  in  10  current piece column, from the position register
cur_y  in  10  current piece row, from the position register
cur_rot  in  10  current rotation, 0..3 in bits [1:0], upper bits 0
chk_req  out  1  collision-check request, level
chk_x  out  10  candidate column
chk_y  out  10  candidate row
chk_rot  out  10  candidate rotation
chk_ack  in  1  checker result valid, 1-cycle pulse
chk_hit  in  1  candidate collides or is out of bounds; valid with chk_ack
new_x  out  10  committed column
new_y  out  10  committed row
new_rot  out  10  committed rotation
refresh  out  1  1-cycle commit strobe to the position register
lock  out  1  1-cycle strobe: write the piece at cur_* into the board
pos_reset  out  1  1-cycle strobe to the position register's err input (respawn)
game_over  out  1  sticky game-over flag

Behaviour:
- Reset values:
  - chk_req, refresh, lock, pos_reset, game_over all 0; chk_*/new_* 0.
  - fall_pend cleared; timeout counter 0; state IDLE.
- States: IDLE, CHECK, COMMIT, LOCK, SPAWN_CHK, RESPAWN, OVER.
- IDLE, event selection (one event per entry, in this priority order):
  - fall_pend or fall_tick: candidate (cur_x, cur_y+1, cur_rot).
  - btn_rot: candidate (cur_x, cur_y, (cur_rot+1) mod 4); 3 wraps to 0.
  - btn_left: candidate (cur_x-1, cur_y, cur_rot).
  - btn_right: candidate (cur_x+1, cur_y, cur_rot).
- btn_left with cur_x==0 is dropped in IDLE: no request, no refresh.
- Candidate capture: on acceptance, the candidate is registered into chk_*, a move-type code is stored, and the FSM goes to CHECK.
- Buttons that arrive outside IDLE are dropped.
- fall_tick that arrives outside IDLE sets fall_pend; fall_pend clears when the down move is accepted in IDLE.
- CHECK:
  - chk_req is held at 1 and chk_* are held stable until chk_ack.
  - chk_ack with chk_hit=0: go to COMMIT.
  - chk_ack with chk_hit=1: if the move was down, go to LOCK; otherwise return to IDLE silently.
  - Counter reaches CHK_TIMEOUT with no ack: treat as a hit.
  - chk_req drops the cycle after the ack or timeout.
- COMMIT:
  - new_* = candidate; refresh=1 for exactly this cycle.
  - Next state IDLE; cur_* are updated on that edge.
  - Minimum latency from event to refresh is 3 cycles (IDLE, CHECK with same-cycle ack, COMMIT).
- LOCK: lock=1 for one cycle; next state SPAWN_CHK.
- SPAWN_CHK:
  - Checks (SPAWN_X, 0, 0) using the same handshake and timeout as CHECK.
  - Clear result: go to RESPAWN.
  - Hit result: game_over=1, pos_reset=1 for one cycle, go to OVER.
- RESPAWN: pos_reset=1 for one cycle; next state IDLE.
- OVER: all inputs ignored, no strobes; leave only on rst.
- Strobe exclusivity: refresh, lock and pos_reset are never asserted in the same cycle.
- rst mid-operation: abandons any check immediately, with chk_req low the next cycle; fall_pend and game_over are cleared.
- Arithmetic:
  - 10-bit unsigned; no saturation on +1.
  - Right, down and rotation bounds are the checker's job, reported via chk_hit.

Decomposition:
- Package tetris_pkg:
  - state enum.
  - move-type enum (MV_DOWN, MV_ROT, MV_LEFT, MV_RIGHT).
  - POS_W=10.
  - ROT_MASK.
- Sub-module chk_handshake: owns the req/ack/timeout counter and returns done/hit; used by both CHECK and SPAWN_CHK.

Test Plan:
1. cur=(5,3,0), fall_tick, ack next cycle with hit=0 -> refresh pulse once with new=(5,4,0), 3 cycles after tick.
2. cur=(5,3,3), btn_rot, hit=0 -> new_rot=0; then cur_x=0 with btn_left -> no chk_req, no refresh.
3. Same-cycle btn_left+btn_rot+fall_tick -> down checked first, other buttons dropped; fall_tick during CHECK -> second down check right after returning to IDLE.
4. Down move hit=1 -> lock pulse, then chk_req with chk=(9,0,0); hit=0 -> pos_reset pulse, state IDLE, game_over=0.
5. Spawn check hit=1 -> pos_reset pulse, game_over=1 sticky; further ticks/buttons produce no chk_req; rst clears game_over.
6. No ack for 15 cycles on a left move -> treated as a hit, returns to IDLE with no refresh; rst asserted mid-CHECK -> chk_req=0 next cycle, all outputs at reset values.
